// File: rtl/i2s_transmitter.sv
// I2S frame master and serializer: buffers one L/R pair, emits lrclk/sdout MSB first,
// and flags frames that start with no pair buffered.
module i2s_transmitter #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned SLOT_W = 32
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] ldata,
   input  logic [DATA_W-1:0] rdata,
   input  logic              dvalid,
   output logic              dready,
   output logic              lrclk,
   output logic              sdout,
   output logic              underrun
);

   localparam int unsigned CNT_W = $clog2(SLOT_W);
   localparam logic [CNT_W-1:0] CntLast    = CNT_W'(SLOT_W - 1);
   localparam logic [CNT_W-1:0] CntDataEnd = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

   typedef enum logic [1:0] {StIdle, StLeft, StRight} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               frame_start;
   logic               hold_full_q, hold_full_d;
   logic [DATA_W-1:0]  hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [DATA_W-1:0]  shift_l_q, shift_l_d, shift_r_q, shift_r_d;
   logic [DATA_W-1:0]  word_d;
   logic               lrclk_q, lrclk_d;
   logic               sdout_q, sdout_d;
   logic               underrun_q, underrun_d;

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // en is only looked at when a new frame could begin.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      frame_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (en) begin
               frame_start = 1'b1;
               state_d     = StLeft;
            end
         end
         StLeft: begin
            if (cnt_q == CntLast) begin
               state_d = StRight;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StRight: begin
            if (cnt_q == CntLast) begin
               cnt_d = '0;
               if (en) begin
                  frame_start = 1'b1;
                  state_d     = StLeft;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      hold_full_d = hold_full_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      shift_l_d   = shift_l_q;
      shift_r_d   = shift_r_q;
      if (frame_start) begin
         if (hold_full_q) begin
            shift_l_d   = hold_l_q;
            shift_r_d   = hold_r_q;
            hold_full_d = 1'b0;
         end else begin
            shift_l_d = '0;
            shift_r_d = '0;
         end
      end else begin
         // The word MSB always drives sdout, so shift once per data bit already sent.
         if (state_q == StLeft && cnt_q != '0) shift_l_d = shift_l_q << 1;
         if (state_q == StRight && cnt_q != '0) shift_r_d = shift_r_q << 1;
      end
      // A pair arriving on the frame-start edge waits for the next frame.
      if (dvalid && !hold_full_q) begin
         hold_l_d    = ldata;
         hold_r_d    = rdata;
         hold_full_d = 1'b1;
      end
   end

   always_comb begin
      word_d     = (state_d == StLeft) ? shift_l_d : shift_r_d;
      lrclk_d    = (state_d == StLeft);
      sdout_d    = (state_d != StIdle) && (cnt_d != '0) && (cnt_d <= CntDataEnd) &&
                   word_d[DATA_W-1];
      underrun_d = frame_start && !hold_full_q;
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         hold_full_q <= 1'b0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         shift_l_q   <= '0;
         shift_r_q   <= '0;
         lrclk_q     <= 1'b0;
         sdout_q     <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         shift_l_q   <= shift_l_d;
         shift_r_q   <= shift_r_d;
         lrclk_q     <= lrclk_d;
         sdout_q     <= sdout_d;
         underrun_q  <= underrun_d;
      end
   end

   assign dready   = !hold_full_q;
   assign lrclk    = lrclk_q;
   assign sdout    = sdout_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: frame-position model checked every cycle, plus a bench-side
// deserializer and directed literal checks on words, pulses and accept spacing.
module tb_i2s_transmitter;

   localparam int DW = 24;
   localparam int SW = 32;
   localparam int FR = 2 * SW;

   logic        sclk = 1'b0;
   logic        rst_n, en, dvalid;
   logic [23:0] ldata, rdata;
   logic        dready, lrclk, sdout, underrun;

   int checks = 0;
   int failures = 0;

   always #5 sclk = ~sclk;

   i2s_transmitter #(.DATA_W(DW), .SLOT_W(SW)) dut (
      .sclk     (sclk),
      .rst_n    (rst_n),
      .en       (en),
      .ldata    (ldata),
      .rdata    (rdata),
      .dvalid   (dvalid),
      .dready   (dready),
      .lrclk    (lrclk),
      .sdout    (sdout),
      .underrun (underrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Model: frame position 0..63 since the last frame start, one pending pair.
   bit          m_active, m_hold_full, m_underrun;
   int          m_pos;
   logic [23:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r;
   wire         m_start = en && (!m_active || m_pos == FR - 1);

   always @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 0; m_pos <= 0; m_hold_full <= 0; m_underrun <= 0;
         m_hold_l <= '0; m_hold_r <= '0; m_cur_l <= '0; m_cur_r <= '0;
      end else begin
         m_underrun <= m_start && !m_hold_full;
         if (m_start) begin
            m_active <= 1;
            m_pos    <= 0;
            if (m_hold_full) begin
               m_cur_l <= m_hold_l; m_cur_r <= m_hold_r; m_hold_full <= 0;
            end else begin
               m_cur_l <= '0; m_cur_r <= '0;
            end
         end else if (m_active && m_pos == FR - 1) begin
            m_active <= 0;
            m_pos    <= 0;
         end else if (m_active) begin
            m_pos <= m_pos + 1;
         end
         if (dvalid && !m_hold_full) begin
            m_hold_l <= ldata; m_hold_r <= rdata; m_hold_full <= 1;
         end
      end
   end

   function automatic logic bit_at(input logic [23:0] w, input int i);
      logic [23:0] t;
      t = w >> i;
      return t[0];
   endfunction

   logic e_lrclk, e_sdout, e_dready, e_underrun;
   always_comb begin
      e_lrclk = m_active && m_pos < SW;
      e_sdout = 1'b0;
      if (m_active && m_pos >= 1 && m_pos <= DW) e_sdout = bit_at(m_cur_l, DW - m_pos);
      else if (m_active && m_pos >= SW + 1 && m_pos <= SW + DW)
         e_sdout = bit_at(m_cur_r, SW + DW - m_pos);
      e_dready   = !m_hold_full;
      e_underrun = m_underrun;
   end

   always @(negedge sclk) begin
      checks++;
      if ({lrclk, sdout, dready, underrun} !== {e_lrclk, e_sdout, e_dready, e_underrun}) begin
         failures++;
         $display("FAIL cycle pos=%0d lrclk/sdout/dready/underrun actual=%b required=%b",
                  m_pos, {lrclk, sdout, dready, underrun},
                  {e_lrclk, e_sdout, e_dready, e_underrun});
      end
   end

   // Independent deserializer keyed on lrclk edges, plus pulse and accept monitors.
   int          rx_bit, cur_bit;
   int          rx_frames = 0;
   int          un_cnt = 0;
   int          cyc = 0;
   int          acc_t[$];
   logic        prev_lr;
   logic [23:0] rx_sh, rx_l, last_l, last_r;

   always_comb begin
      if (lrclk != prev_lr) cur_bit = 0;
      else if (rx_bit >= 1000) cur_bit = 1000;
      else cur_bit = rx_bit + 1;
   end

   always @(negedge sclk) begin
      if (!rst_n) begin
         rx_bit  <= 1000;
         prev_lr <= 1'b0;
      end else begin
         prev_lr <= lrclk;
         rx_bit  <= cur_bit;
         if (underrun) un_cnt <= un_cnt + 1;
         if (cur_bit >= 1 && cur_bit <= DW) rx_sh <= {rx_sh[22:0], sdout};
         if (cur_bit == DW) begin
            if (lrclk) rx_l <= {rx_sh[22:0], sdout};
            else begin
               last_l    <= rx_l;
               last_r    <= {rx_sh[22:0], sdout};
               rx_frames <= rx_frames + 1;
            end
         end
      end
   end

   always @(posedge sclk) begin
      cyc <= cyc + 1;
      if (rst_n && dvalid && dready) acc_t.push_back(cyc);
   end

   task automatic wait_frames(input int n, input string name);
      int target = rx_frames + n;
      int k = 0;
      while (rx_frames < target && k < n * FR + 100) begin
         @(negedge sclk);
         k++;
      end
      chk({name, "_frames_seen"}, 32'(rx_frames >= target), 32'd1);
   endtask

   task automatic wait_pos(input int p, input bit need_empty, input string name);
      int k = 0;
      while (!(m_active && m_pos == p && (!need_empty || !m_hold_full)) && k < 300) begin
         @(negedge sclk);
         k++;
      end
      chk({name, "_pos_reached"}, 32'(k < 300), 32'd1);
   endtask

   task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
      int k = 0;
      while (!dready && k < 200) begin
         @(negedge sclk);
         k++;
      end
      chk("send_dready_seen", 32'(dready), 32'd1);
      ldata  = l;
      rdata  = r;
      dvalid = 1'b1;
      @(negedge sclk);
      dvalid = 1'b0;
   endtask

   initial begin
      int ones, uns, n, un0, nacc0, lr_high;
      rst_n = 1'b1; en = 1'b0; dvalid = 1'b0; ldata = '0; rdata = '0;
      #1 rst_n = 1'b0;
      en = 1'b1;
      repeat (3) @(negedge sclk);
      chk("rst_lrclk", 32'(lrclk), 0);
      chk("rst_sdout", 32'(sdout), 0);
      chk("rst_dready", 32'(dready), 1);
      chk("rst_underrun", 32'(underrun), 0);

      // Release: first edge starts an empty frame.
      rst_n = 1'b1;
      @(posedge sclk); #1;
      chk("t1_lrclk_rise", 32'(lrclk), 1);
      chk("t1_underrun", 32'(underrun), 1);
      @(negedge sclk);
      send_pair(24'h123456, 24'hABCDEF);
      ones = 0; uns = 0;
      for (int i = 0; i < 55; i++) begin
         @(negedge sclk);
         ones += int'(sdout);
         uns  += int'(underrun);
      end
      chk("t1_sdout_zero", 32'(ones), 0);
      chk("t1_single_pulse", 32'(uns), 0);
      wait_frames(1, "t1");
      chk("t1_word_l", 32'(last_l), 32'h000000);
      chk("t1_word_r", 32'(last_r), 32'h000000);
      wait_frames(1, "t2");
      chk("t2_word_l", 32'(last_l), 32'h123456);
      chk("t2_word_r", 32'(last_r), 32'hABCDEF);

      // Continuous streaming of L=-1, R=most negative.
      nacc0 = acc_t.size();
      un0   = un_cnt;
      ldata = 24'hFFFFFF; rdata = 24'h800000; dvalid = 1'b1;
      wait_frames(4, "t3");
      chk("t3_word_l", 32'(last_l), 32'hFFFFFF);
      chk("t3_word_r", 32'(last_r), 32'h800000);
      chk("t3_no_underrun", 32'(un_cnt - un0), 0);
      n = acc_t.size();
      chk("t4_accept_count", 32'(n - nacc0), 5);
      chk("t4_spacing_a", 32'(acc_t[n-1] - acc_t[n-2]), 64);
      chk("t4_spacing_b", 32'(acc_t[n-2] - acc_t[n-3]), 64);

      // Pair offered exactly on the frame-start edge with an empty buffer.
      dvalid = 1'b0;
      wait_pos(FR - 1, 1'b1, "t5");
      ldata = 24'h5A5A5A; rdata = 24'h3C3C3C; dvalid = 1'b1;
      @(posedge sclk); #1;
      chk("t5_underrun", 32'(underrun), 1);
      chk("t5_captured", 32'(dready), 0);
      @(negedge sclk);
      dvalid = 1'b0;
      wait_frames(1, "t5a");
      chk("t5_zero_l", 32'(last_l), 0);
      chk("t5_zero_r", 32'(last_r), 0);
      wait_frames(1, "t5b");
      chk("t5_word_l", 32'(last_l), 32'h5A5A5A);
      chk("t5_word_r", 32'(last_r), 32'h3C3C3C);

      // en dropped early in LEFT: frame completes, then idle.
      wait_pos(5, 1'b0, "t6");
      en = 1'b0;
      repeat (70) @(negedge sclk);
      lr_high = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge sclk);
         lr_high += int'(lrclk) + int'(sdout);
      end
      chk("t6_idle_quiet", 32'(lr_high), 0);

      // Asynchronous reset in the middle of a slot.
      send_pair(24'hFFFFFF, 24'hFFFFFF);
      en = 1'b1;
      wait_pos(3, 1'b0, "t6b");
      send_pair(24'h111111, 24'h222222);
      wait_pos(10, 1'b0, "t6c");
      chk("t6_pre_lrclk", 32'(lrclk), 1);
      chk("t6_pre_sdout", 32'(sdout), 1);
      chk("t6_pre_dready", 32'(dready), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_lrclk", 32'(lrclk), 0);
      chk("t6_rst_sdout", 32'(sdout), 0);
      chk("t6_rst_dready", 32'(dready), 1);
      chk("t6_rst_underrun", 32'(underrun), 0);
      repeat (2) @(negedge sclk);
      rst_n = 1'b1;
      repeat (5) @(negedge sclk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
